// File: rtl/sequenciador_uc.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator processor.
// Owns PC, IR, A and B; drives the 16x8 synchronous RAM and the combinational ULA.
module sequenciador_uc #(
    parameter logic [3:0] RESET_PC        = 4'h0,
    parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic       step,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_rd,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    output logic [7:0] reg_a,
    output logic [7:0] reg_b,
    output logic [3:0] pc,
    output logic [7:0] ir,
    output logic [2:0] state_dbg,
    output logic       retire,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_FETCH_W = 3'd2,
        S_DECODE  = 3'd3,
        S_MEM_W   = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [3:0] op, opnd;
    logic       done;

    assign op        = ir_q[7:4];
    assign opnd      = ir_q[3:0];
    assign alu_op    = ir_q[7:4];
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign mem_wdata = a_q;
    assign reg_a     = a_q;
    assign reg_b     = b_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign state_dbg = state_q;
    assign halted    = (state_q == S_HALT);

    // Strobes are decoded from the registered state so reset clears them at once.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        mem_rd   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        retire   = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run || step) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_rd  = 1'b1;
                state_d = S_FETCH_W;
            end
            S_FETCH_W: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 4'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                done = 1'b1;
                case (op)
                    4'h1, 4'h3: begin
                        mem_rd   = 1'b1;
                        mem_addr = opnd;
                        state_d  = S_MEM_W;
                        done     = 1'b0;
                    end
                    4'h2: begin
                        mem_we   = 1'b1;
                        mem_addr = opnd;
                    end
                    4'h4, 4'h5, 4'h6, 4'h7: a_d = alu_result;
                    4'h8: a_d = {4'h0, opnd};
                    4'h9: pc_d = opnd;
                    4'hA: if (a_q == '0) pc_d = opnd;
                    4'hF: begin
                        state_d = S_HALT;
                        done    = 1'b0;
                    end
                    4'h0: ;
                    default: begin
                        if (HALT_ON_ILLEGAL) begin
                            state_d = S_HALT;
                            done    = 1'b0;
                        end
                    end
                endcase
            end
            S_MEM_W: begin
                mem_addr = opnd;
                if (op == 4'h1) a_d = mem_rdata;
                else            b_d = mem_rdata;
                done = 1'b1;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
        // Every retiring instruction chooses between next fetch and idle here.
        if (done) begin
            retire  = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule

// File: tb/tb_sequenciador_uc.sv
// Bench for sequenciador_uc: RAM/ULA models plus an instruction-level reference model.
module tb_sequenciador_uc;
    localparam logic [3:0] RPC = 4'h0;

    logic       clock = 1'b0, reset_n = 1'b0, run = 1'b0, step = 1'b0;
    logic [3:0] mem_addr, alu_op, pc;
    logic [7:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_result, reg_a, reg_b, ir;
    logic       mem_rd, mem_we, retire, halted;
    logic [2:0] state_dbg;

    int n_chk = 0, n_err = 0;

    always #5 clock = ~clock;

    sequenciador_uc #(.RESET_PC(RPC), .HALT_ON_ILLEGAL(1'b0)) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .step(step),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .reg_a(reg_a), .reg_b(reg_b), .pc(pc), .ir(ir),
        .state_dbg(state_dbg), .retire(retire), .halted(halted)
    );

    // 16x8 synchronous RAM, with a loader port used while the DUT is in reset
    logic [7:0] ram [16];
    logic       ld_en = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    always @(posedge clock) begin
        if (ld_en)       ram[ld_addr]  <= ld_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    always_comb begin
        case (alu_op)
            4'h4:    alu_result = alu_a + alu_b;
            4'h5:    alu_result = alu_a - alu_b;
            4'h6:    alu_result = alu_a & alu_b;
            4'h7:    alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
    end

    // Architectural reference model
    logic [7:0] prog  [16];
    logic [7:0] m_mem [16];
    logic [7:0] m_a, m_b;
    logic [3:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [7:0] ins);
        return (ins[7:4] == 4'h1 || ins[7:4] == 4'h3) ? 4 : 3;
    endfunction

    task automatic model_exec();
        logic [7:0] ins;
        logic [3:0] k;
        ins  = m_mem[m_pc];
        k    = ins[3:0];
        m_pc = m_pc + 4'd1;
        case (ins[7:4])
            4'h1: m_a = m_mem[k];
            4'h2: m_mem[k] = m_a;
            4'h3: m_b = m_mem[k];
            4'h4: m_a = m_a + m_b;
            4'h5: m_a = m_a - m_b;
            4'h6: m_a = m_a & m_b;
            4'h7: m_a = m_a | m_b;
            4'h8: m_a = {4'h0, k};
            4'h9: m_pc = k;
            4'hA: if (m_a == '0) m_pc = k;
            default: ;
        endcase
    endtask

    task automatic load_and_reset();
        @(negedge clock);
        reset_n = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ld_en   = 1'b1;
            ld_addr = i[3:0];
            ld_data = prog[i];
            @(negedge clock);
        end
        ld_en = 1'b0;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_pc", 32'(pc), 32'(RPC));
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_a", 32'(reg_a), 32'd0);
        check("rst_b", 32'(reg_b), 32'd0);
        check("rst_strobes", 32'({mem_rd, mem_we, retire, halted}), 32'd0);
        reset_n = 1'b1;
        m_mem = prog;
        m_a   = '0;
        m_b   = '0;
        m_pc  = RPC;
        @(negedge clock);
        check("idle_hold", 32'(state_dbg), 32'd0);
    endtask

    // Free-runs until HALT or max_ret retires; k counts cycles from the first FETCH
    task automatic run_prog(input int max_ret, output int nret, output int halt_k);
        int start;
        logic pend;
        logic [7:0] ins;
        nret = 0; halt_k = -1; start = 0; pend = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            check("rd_we_excl", 32'(mem_rd & mem_we), 32'd0);
            if (pend) begin
                check("A", 32'(reg_a), 32'(m_a));
                check("B", 32'(reg_b), 32'(m_b));
                check("PC", 32'(pc), 32'(m_pc));
                pend = 1'b0;
                if (nret >= max_ret) begin
                    run = 1'b0;
                    return;
                end
            end
            ins = m_mem[m_pc];
            if (retire) begin
                check("retire_not_hlt", 32'(ins[7:4] == 4'hF), 32'd0);
                check("latency", 32'(k - start), 32'(lat_of(ins) - 1));
                model_exec();
                nret++;
                pend  = 1'b1;
                start = k + 1;
            end
            if (halted) begin
                check("halt_ins", 32'(ins[7:4]), 32'hF);
                check("halt_lat", 32'(k - start), 32'd3);
                halt_k = k;
                run = 1'b0;
                return;
            end
        end
        check("timeout", 32'd1, 32'd0);
        run = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    initial begin
        int nret, hk, w;

        // Program: LDI 5; LDB E; ADD; STA F; HLT with M[E]=03
        clear_prog();
        prog[0] = 8'h85; prog[1] = 8'h3E; prog[2] = 8'h40; prog[3] = 8'h2F; prog[4] = 8'hF0;
        prog[14] = 8'h03;
        load_and_reset();
        run_prog(50, nret, hk);
        check("p1_retires", 32'(nret), 32'd4);
        check("p1_halt_cycle", 32'(hk), 32'd16);
        check("p1_A", 32'(reg_a), 32'h08);
        check("p1_B", 32'(reg_b), 32'h03);
        check("p1_MF", 32'(ram[15]), 32'h08);
        @(negedge clock);
        check("p1_halt_hold", 32'({halted, mem_rd, mem_we, state_dbg}), 32'({1'b1, 1'b0, 1'b0, 3'd5}));

        // SUB/ADD wrap and both JZ outcomes
        clear_prog();
        prog[0] = 8'h82; prog[1] = 8'h3E; prog[2] = 8'h50; prog[3] = 8'hA7;
        prog[4] = 8'h3D; prog[5] = 8'h40; prog[6] = 8'hA9; prog[9] = 8'hF0;
        prog[13] = 8'h01; prog[14] = 8'h03;
        load_and_reset();
        run_prog(50, nret, hk);
        check("p2_retires", 32'(nret), 32'd7);
        check("p2_A", 32'(reg_a), 32'h00);
        check("p2_pc", 32'(pc), 32'hA);

        // NOP at F wraps to 0
        clear_prog();
        prog[0] = 8'h9F; prog[1] = 8'hF0; prog[15] = 8'h00;
        load_and_reset();
        run_prog(3, nret, hk);
        check("p3_retires", 32'(nret), 32'd3);

        // Single step; a step during FETCH_W is ignored
        clear_prog();
        prog[0] = 8'h81;
        load_and_reset();
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        check("step_fetch", 32'(state_dbg), 32'd1);
        nret = 0;
        for (int i = 0; i < 12; i++) begin
            if (retire) nret++;
            step = (state_dbg == 3'd2);
            @(negedge clock);
        end
        step = 1'b0;
        check("step_retires", 32'(nret), 32'd1);
        check("step_idle", 32'(state_dbg), 32'd0);
        check("step_A", 32'(reg_a), 32'h01);
        check("step_pc", 32'(pc), 32'h1);

        // Asynchronous reset during MEM_W of LDA
        clear_prog();
        prog[0] = 8'h87; prog[1] = 8'h1E; prog[14] = 8'h55;
        load_and_reset();
        run = 1'b1;
        for (w = 0; w < 20 && state_dbg != 3'd4; w++) @(negedge clock);
        check("memw_reach", 32'(state_dbg), 32'd4);
        check("memw_A_before", 32'(reg_a), 32'h07);
        reset_n = 1'b0;
        #1;
        check("arst_rd", 32'(mem_rd), 32'd0);
        check("arst_A", 32'(reg_a), 32'd0);
        check("arst_state", 32'(state_dbg), 32'd0);
        check("arst_retire", 32'(retire), 32'd0);
        @(negedge clock);
        run = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_state", 32'(state_dbg), 32'd0);
        check("post_rst_pc", 32'(pc), 32'(RPC));

        // Random programs against the reference model
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
            load_and_reset();
            run_prog(30, nret, hk);
            for (int i = 0; i < 16; i++) check("rand_mem", 32'(ram[i]), 32'(m_mem[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
